pipeline_hazard_ctrl: RTL and testbench

Central pipeline control for the five-stage datapath. It computes the per-cycle advance enable, bubble-insert stall, and wrong-path flush that every inter-stage latch consumes. It tracks instruction and data memory waits, detects load-use hazards between ID and EX, and latches processor halt. It sits beside the stage latches and drives their enable, stall and flush inputs plus the PC write enable.

---
 rtl/pipeline_hazard_ctrl.sv | 104 ++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Central pipeline control: advance/stall/flush/PC-enable, memory-wait tracking and halt latch.
// Optional performance counters are built when HAZARD_PERF_EN is defined; otherwise the counter ports read 0.
module pipeline_hazard_ctrl #(
  parameter int MAX_WAIT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        mem_req,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic [4:0]  ex_dest,
  input  logic        ex_regwen,
  input  logic        ex_mem2reg,
  input  logic        ex_redirect,
  input  logic        wb_halt,
  output logic        adv,
  output logic        stall,
  output logic        flush,
  output logic        pc_en,
  output logic        halted,
  output logic        timeout,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
  output logic [31:0] wait_total,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_IWAIT = 2'd1,
    S_DWAIT = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [15:0] MAX_W = 16'(MAX_WAIT);

  state_t      state, state_nxt;
  logic [15:0] wait_ctr, wait_ctr_nxt;
  logic        mem_ok;
  logic        lu;

  always_comb begin
    mem_ok    = !mem_req || dhit;
    lu        = ex_mem2reg && ex_regwen && (ex_dest != 5'd0) &&
                ((id_use_rs && (id_rs == ex_dest)) || (id_use_rt && (id_rt == ex_dest)));
    adv       = !RST && (state != S_HALT) && ihit && mem_ok;
    // A redirect squashes the dependent instruction, so it overrides the load-use bubble.
    flush     = adv && ex_redirect;
    stall     = adv && lu && !ex_redirect;
    pc_en     = adv && !stall;
    state_nxt = state;
    if (state != S_HALT) begin
      if (wb_halt && adv)          state_nxt = S_HALT;
      else if (mem_req && !dhit)   state_nxt = S_DWAIT;
      else if (!ihit)              state_nxt = S_IWAIT;
      else                         state_nxt = S_RUN;
    end
    if (adv || (state == S_HALT))  wait_ctr_nxt = 16'd0;
    else if (wait_ctr >= MAX_W)    wait_ctr_nxt = MAX_W;
    else                           wait_ctr_nxt = wait_ctr + 16'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_RUN;
      wait_ctr <= 16'd0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_ctr <= wait_ctr_nxt;
      // Sticky: raised on the edge where the wait count reaches MAX_WAIT.
      timeout  <= timeout || (wait_ctr_nxt == MAX_W);
    end
  end

  assign halted    = (state == S_HALT);
  assign state_dbg = state;

`ifdef HAZARD_PERF_EN
  logic wait_en;
  assign wait_en = !adv && (state != S_HALT) && !RST;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt  <= 32'd0;
      flush_cnt  <= 32'd0;
      wait_total <= 32'd0;
    end else begin
      if (stall && (stall_cnt != 32'hFFFF_FFFF))    stall_cnt  <= stall_cnt + 32'd1;
      if (flush && (flush_cnt != 32'hFFFF_FFFF))    flush_cnt  <= flush_cnt + 32'd1;
      if (wait_en && (wait_total != 32'hFFFF_FFFF)) wait_total <= wait_total + 32'd1;
    end
  end
`else
  assign stall_cnt  = 32'd0;
  assign flush_cnt  = 32'd0;
  assign wait_total = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int MAXW = 4;
  localparam logic [1:0] ST_RUN = 2'd0, ST_IWAIT = 2'd1, ST_DWAIT = 2'd2, ST_HALT = 2'd3;

  logic        CLK, RST;
  logic        ihit, dhit, mem_req;
  logic [4:0]  id_rs, id_rt, ex_dest;
  logic        id_use_rs, id_use_rt, ex_regwen, ex_mem2reg, ex_redirect, wb_halt;
  logic        adv, stall, flush, pc_en, halted, timeout;
  logic [31:0] stall_cnt, flush_cnt, wait_total;
  logic [1:0]  state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  pipeline_hazard_ctrl #(.MAX_WAIT(MAXW)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_dest(ex_dest), .ex_regwen(ex_regwen), .ex_mem2reg(ex_mem2reg),
    .ex_redirect(ex_redirect), .wb_halt(wb_halt),
    .adv(adv), .stall(stall), .flush(flush), .pc_en(pc_en), .halted(halted),
    .timeout(timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .wait_total(wait_total), .state_dbg(state_dbg)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // behavioural model: halted flag, kind of pending miss, consecutive wait count, event tallies
  bit     m_halt, m_dmiss, m_imiss, m_timeout;
  int     m_waits;
  longint m_stalls, m_flushes, m_waittot;

  function automatic logic [3:0] exp_ctl(input bit halt_now);
    bit a, hz, st, fl;
    a  = !RST && !halt_now && ihit && (!mem_req || dhit);
    hz = ex_mem2reg && ex_regwen && ex_dest != 0 &&
         ((id_use_rs && id_rs == ex_dest) || (id_use_rt && id_rt == ex_dest));
    fl = a && ex_redirect;
    st = a && hz && !ex_redirect;
    return {a, st, fl, a && !st};
  endfunction

  function automatic logic [1:0] exp_state();
    if (RST)     return ST_RUN;
    if (m_halt)  return ST_HALT;
    if (m_dmiss) return ST_DWAIT;
    if (m_imiss) return ST_IWAIT;
    return ST_RUN;
  endfunction

  always @(posedge CLK) begin
    logic [3:0] e;
    if (RST) begin
      m_halt = 0; m_dmiss = 0; m_imiss = 0; m_timeout = 0; m_waits = 0;
      m_stalls = 0; m_flushes = 0; m_waittot = 0;
    end else begin
      e = exp_ctl(m_halt);
      if (e[2] && m_stalls  < 64'hFFFF_FFFF) m_stalls++;
      if (e[1] && m_flushes < 64'hFFFF_FFFF) m_flushes++;
      if (!e[3] && !m_halt && m_waittot < 64'hFFFF_FFFF) m_waittot++;
      if (e[3] || m_halt) m_waits = 0;
      else if (m_waits < MAXW) m_waits++;
      if (m_waits == MAXW) m_timeout = 1;
      if (!m_halt) begin
        m_halt  = wb_halt && e[3];
        m_dmiss = mem_req && !dhit;
        m_imiss = !ihit;
      end
    end
  end

  // scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    logic [3:0] e;
    logic [31:0] es, ef, ew;
    e  = exp_ctl(m_halt);
`ifdef HAZARD_PERF_EN
    es = RST ? 32'd0 : 32'(m_stalls);
    ef = RST ? 32'd0 : 32'(m_flushes);
    ew = RST ? 32'd0 : 32'(m_waittot);
`else
    es = 32'd0; ef = 32'd0; ew = 32'd0;
`endif
    chk("adv",        {31'd0, adv},     {31'd0, e[3]});
    chk("stall",      {31'd0, stall},   {31'd0, e[2]});
    chk("flush",      {31'd0, flush},   {31'd0, e[1]});
    chk("pc_en",      {31'd0, pc_en},   {31'd0, e[0]});
    chk("halted",     {31'd0, halted},  {31'd0, !RST && m_halt});
    chk("timeout",    {31'd0, timeout}, {31'd0, !RST && m_timeout});
    chk("state",      {30'd0, state_dbg}, {30'd0, exp_state()});
    chk("stall_cnt",  stall_cnt,  es);
    chk("flush_cnt",  flush_cnt,  ef);
    chk("wait_total", wait_total, ew);
  end

  // driver tasks
  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic mid();
    @(negedge CLK); #1;
  endtask

  task automatic idle_inputs();
    ihit = 1; dhit = 0; mem_req = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    ex_dest = 0; ex_regwen = 0; ex_mem2reg = 0; ex_redirect = 0; wb_halt = 0;
  endtask

  task automatic set_hazard(input logic [4:0] r);
    ex_mem2reg = 1; ex_regwen = 1; ex_dest = r; id_rs = r; id_use_rs = 1;
  endtask

  initial begin
    RST = 1;
    idle_inputs();
    repeat (3) tick();
    mid();
    chk("rst_adv", {31'd0, adv}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_state", {30'd0, state_dbg}, {30'd0, ST_RUN});
    chk("rst_wait_total", wait_total, 32'd0);

    tick(); RST = 0;
    mid(); chk("run_adv", {31'd0, adv}, 32'd1);

    // load-use hazard, then r0, then redirect wins
    tick(); set_hazard(5'd5);
    mid(); chk("lu_stall", {31'd0, stall}, 32'd1); chk("lu_pc_en", {31'd0, pc_en}, 32'd0);
    chk("lu_flush", {31'd0, flush}, 32'd0);
    tick(); set_hazard(5'd0);
    mid(); chk("r0_stall", {31'd0, stall}, 32'd0); chk("r0_pc_en", {31'd0, pc_en}, 32'd1);
    tick(); set_hazard(5'd5); ex_redirect = 1;
    mid(); chk("redir_flush", {31'd0, flush}, 32'd1); chk("redir_stall", {31'd0, stall}, 32'd0);
    chk("redir_pc_en", {31'd0, pc_en}, 32'd1);

    // data miss for 3 cycles
    tick(); idle_inputs(); mem_req = 1; dhit = 0;
    mid(); chk("dmiss_adv", {31'd0, adv}, 32'd0);
    tick(); tick();
    mid(); chk("dmiss_state", {30'd0, state_dbg}, {30'd0, ST_DWAIT});
    tick(); dhit = 1;
    mid(); chk("dhit_adv", {31'd0, adv}, 32'd1);
    tick(); mem_req = 0; dhit = 0;
    mid(); chk("after_dhit_state", {30'd0, state_dbg}, {30'd0, ST_RUN});
`ifdef HAZARD_PERF_EN
    chk("dmiss_wait_total", wait_total, 32'd3);
`endif

    // timeout with ihit low for 6 cycles
    tick(); ihit = 0;
    tick(); tick(); tick();
    mid(); chk("to_before", {31'd0, timeout}, 32'd0);
    tick();
    mid(); chk("to_set", {31'd0, timeout}, 32'd1);
    tick(); tick(); ihit = 1;
    mid(); chk("to_sticky", {31'd0, timeout}, 32'd1); chk("to_adv", {31'd0, adv}, 32'd1);
    tick(); RST = 1;
    mid(); chk("to_rst", {31'd0, timeout}, 32'd0);
    tick(); RST = 0;

    // halt
    wb_halt = 1;
    mid(); chk("halt_adv", {31'd0, adv}, 32'd1); chk("halt_pre", {31'd0, halted}, 32'd0);
    tick(); wb_halt = 0; ex_redirect = 1;
    mid(); chk("halted", {31'd0, halted}, 32'd1); chk("halt_flush", {31'd0, flush}, 32'd0);
    chk("halt_pc_en", {31'd0, pc_en}, 32'd0); chk("halt_adv_off", {31'd0, adv}, 32'd0);
    tick();
    mid(); chk("halt_hold", {31'd0, halted}, 32'd1);

    // async reset mid-DWAIT
    tick(); RST = 1;
    tick(); RST = 0; ex_redirect = 0; mem_req = 1; dhit = 0;
    tick(); tick();
    mid(); chk("pre_arst_state", {30'd0, state_dbg}, {30'd0, ST_DWAIT});
    @(posedge CLK); #3; RST = 1; #1;
    chk("arst_adv", {31'd0, adv}, 32'd0);
    chk("arst_state", {30'd0, state_dbg}, {30'd0, ST_RUN});
    mem_req = 0; ihit = 1;
    tick(); RST = 0;
    mid(); chk("arst_release_adv", {31'd0, adv}, 32'd1);

    // randomized traffic, checked by the compare process
    for (int i = 0; i < 3000; i++) begin
      tick();
      RST         = ($urandom_range(0, 149) == 0);
      ihit        = ($urandom_range(0, 5) != 0);
      mem_req     = ($urandom_range(0, 2) == 0);
      dhit        = ($urandom_range(0, 2) != 0);
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      id_use_rs   = 1'($urandom_range(0, 1));
      id_use_rt   = 1'($urandom_range(0, 1));
      ex_dest     = 5'($urandom_range(0, 3));
      ex_regwen   = ($urandom_range(0, 3) != 0);
      ex_mem2reg  = 1'($urandom_range(0, 1));
      ex_redirect = ($urandom_range(0, 4) == 0);
      wb_halt     = ($urandom_range(0, 99) == 0);
    end
    tick(); RST = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
